sprite_load_arbiter: RTL and testbench

Shares the single-port sprite image BRAM between the video read path and a streaming image loader. Each cycle it grants the port either to the raster read (current hcount/vcount inside the sprite rectangle) or to a pending loader write, using a valid/ready handshake for the loader. It sits between the video timing generator, a byte-stream source (UART/loader FSM) and the image/palette BRAM pair. It also emits an `in_sprite` flag delayed to line up with palette output.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_delay.sv | 38 +++
 rtl/sprite_load_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sprite_load_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite load arbiter.
//   state_e          - loader FSM states (IDLE, LOAD)
//   calc_aw()        - image BRAM address width for a WIDTH x HEIGHT sprite
//   DEFAULT_H_ACTIVE - default visible pixels per line
//   DEFAULT_V_ACTIVE - default visible lines per frame
package sprite_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    localparam int DEFAULT_H_ACTIVE = 1280;
    localparam int DEFAULT_V_ACTIVE = 720;

    function automatic int calc_aw(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

// File: rtl/sprite_delay.sv
// sprite_delay: fixed-depth shift register with asynchronous active-low clear.
// Used to align the in_sprite flag with palette data at the end of the read pipe.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low clear of every stage
//   din   - value entering the pipe
//   dout  - value that entered DEPTH cycles earlier
module sprite_delay
    import sprite_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift pipe: stage 0 takes the input, each later stage takes its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/sprite_load_arbiter.sv
// sprite_load_arbiter: shares the single-port sprite image BRAM between the
// raster read path and a streaming image loader (valid/ready byte stream).
// The raster read always wins; loader bytes are accepted only inside the
// write window while a load is in progress.
//
// Build option: define SPRITE_LOAD_BLANK_ONLY_EN to restrict loader writes to
// the blanking interval; otherwise writes go through on any non-sprite pixel.
//
// Ports:
//   pixel_clk_in, rst_n_in     - clock, asynchronous active-low reset
//   hcount_in, vcount_in       - raster position
//   x_in, y_in                 - sprite top-left corner
//   load_start_in/abort_in     - begin / abandon a full image load
//   wr_data_in/valid_in/ready_out - loader byte stream handshake
//   busy_out, done_out         - load in progress / last byte accepted
//   ram_addr_out/din_out/we_out - registered image BRAM port
//   in_sprite_out              - in_sprite aligned with palette output
module sprite_load_arbiter
    import sprite_pkg::*;
#(
    parameter int  WIDTH        = 256,
    parameter int  HEIGHT       = 256,
    parameter int  H_ACTIVE     = DEFAULT_H_ACTIVE,
    parameter int  V_ACTIVE     = DEFAULT_V_ACTIVE,
    parameter int  READ_LATENCY = 5,
    localparam int AW           = calc_aw(WIDTH, HEIGHT)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_n_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic [10:0]   x_in,
    input  logic [9:0]    y_in,
    input  logic          load_start_in,
    input  logic          load_abort_in,
    input  logic [7:0]    wr_data_in,
    input  logic          wr_valid_in,
    output logic          wr_ready_out,
    output logic          busy_out,
    output logic          done_out,
    output logic [AW-1:0] ram_addr_out,
    output logic [7:0]    ram_din_out,
    output logic          ram_we_out,
    output logic          in_sprite_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

    // The blanking thresholds are compared against 11/10-bit counters.
    if (H_ACTIVE > 2047 || V_ACTIVE > 1023) begin : g_bad_active
        $error("H_ACTIVE/V_ACTIVE do not fit the raster counter widths");
    end

    state_e          state_r;
    state_e          state_next_s;
    logic [AW-1:0]   wr_addr_r;
    logic [AW-1:0]   wr_addr_next_s;
    logic [11:0]     x_end_s;
    logic [10:0]     y_end_s;
    logic            in_sprite_s;
    logic [10:0]     h_off_s;
    logic [9:0]      v_off_s;
    logic [AW-1:0]   rd_addr_s;
    logic            write_window_s;
    logic            wr_ready_s;
    logic            accept_s;
    logic            last_byte_s;

    // Sprite extents one bit wider than the counters so a sprite hanging off
    // the right/bottom edge never wraps back to column/row zero.
    assign x_end_s = {1'b0, x_in} + 12'(WIDTH);
    assign y_end_s = {1'b0, y_in} + 11'(HEIGHT);

    assign in_sprite_s = (hcount_in >= x_in) && ({1'b0, hcount_in} < x_end_s) &&
                         (vcount_in >= y_in) && ({1'b0, vcount_in} < y_end_s);

    assign h_off_s   = hcount_in - x_in;
    assign v_off_s   = vcount_in - y_in;
    assign rd_addr_s = AW'(h_off_s) + AW'(v_off_s) * AW'(WIDTH);

`ifdef SPRITE_LOAD_BLANK_ONLY_EN
    // Blanking only; a sprite placed in the blanking area still keeps its read slot.
    assign write_window_s = ((hcount_in >= 11'(H_ACTIVE)) || (vcount_in >= 10'(V_ACTIVE))) &&
                            !in_sprite_s;
`else
    assign write_window_s = !in_sprite_s;
`endif

    assign wr_ready_s  = (state_r == LOAD) && write_window_s;
    // Abort takes precedence: a byte offered alongside abort is not taken.
    assign accept_s    = wr_ready_s && wr_valid_in && !load_abort_in;
    assign last_byte_s = (wr_addr_r == LAST_ADDR);

    assign wr_ready_out = wr_ready_s;
    assign busy_out     = (state_r == LOAD);
    assign done_out     = accept_s && last_byte_s;

    // Next-state and write-pointer logic for the loader FSM.
    always_comb begin
        state_next_s   = state_r;
        wr_addr_next_s = wr_addr_r;
        case (state_r)
            IDLE: begin
                if (load_abort_in) begin
                    state_next_s = IDLE;
                end else if (load_start_in) begin
                    state_next_s   = LOAD;
                    wr_addr_next_s = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (load_abort_in) begin
                    state_next_s   = IDLE;
                    wr_addr_next_s = '0;
                end else if (accept_s) begin
                    if (last_byte_s) begin
                        state_next_s   = IDLE;
                        wr_addr_next_s = '0;
                    end else begin
                        wr_addr_next_s = wr_addr_r + AW'(1);
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            default: begin
                state_next_s   = IDLE;
                wr_addr_next_s = '0;
            end
        endcase
    end

    // FSM state and write pointer registers.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= IDLE;
            wr_addr_r <= '0;
        end else begin
            state_r   <= state_next_s;
            wr_addr_r <= wr_addr_next_s;
        end
    end

    // Image BRAM port: accepted loader bytes write, otherwise the raster read
    // address is tracked while inside the sprite and held elsewhere.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ram_addr_out <= '0;
            ram_din_out  <= 8'h00;
            ram_we_out   <= 1'b0;
        end else if (accept_s) begin
            ram_addr_out <= wr_addr_r;
            ram_din_out  <= wr_data_in;
            ram_we_out   <= 1'b1;
        end else begin
            ram_we_out <= 1'b0;
            if (in_sprite_s) begin
                ram_addr_out <= rd_addr_s;
            end else begin
                ram_addr_out <= ram_addr_out;
            end
        end
    end

    sprite_delay #(
        .DEPTH (READ_LATENCY),
        .W     (1)
    ) u_in_sprite_delay (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .din   (in_sprite_s),
        .dout  (in_sprite_out)
    );

endmodule

// File: tb/tb_sprite_load_arbiter.sv
// Self-checking bench for sprite_load_arbiter: reset checks, a table of raster
// read vectors, directed load/abort/reset sequences, a full image load and
// randomized traffic against a behavioural reference model.
module tb_sprite_load_arbiter;

    localparam int WIDTH    = 256;
    localparam int HEIGHT   = 256;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int LAT      = 5;
    localparam int NPIX     = WIDTH * HEIGHT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount, x;
    logic [9:0]  vcount, y;
    logic        load_start, load_abort, wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready, busy, done, ram_we, in_sprite_o;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;

    always #5 clk = ~clk;

    sprite_load_arbiter dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .x_in          (x),
        .y_in          (y),
        .load_start_in (load_start),
        .load_abort_in (load_abort),
        .wr_data_in    (wr_data),
        .wr_valid_in   (wr_valid),
        .wr_ready_out  (wr_ready),
        .busy_out      (busy),
        .done_out      (done),
        .ram_addr_out  (ram_addr),
        .ram_din_out   (ram_din),
        .ram_we_out    (ram_we),
        .in_sprite_out (in_sprite_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_loading;
    int m_idx;
    bit m_we;
    int m_addr;
    int m_din;
    bit m_hist [LAT];
    bit last_acc;
    int done_seen;

    typedef struct {
        int h; int v; int x; int y; int exp_in; int exp_addr;
    } vec_t;
    vec_t tbl [11];

    function automatic bit f_in(int h, int v, int xx, int yy);
        return (h >= xx) && (h < xx + WIDTH) && (v >= yy) && (v < yy + HEIGHT);
    endfunction

    function automatic int f_rd(int h, int v, int xx, int yy);
        return ((h - xx) + (v - yy) * WIDTH) % NPIX;
    endfunction

    function automatic bit f_window(int h, int v, int xx, int yy);
`ifdef SPRITE_LOAD_BLANK_ONLY_EN
        return (h >= H_ACTIVE || v >= V_ACTIVE) && !f_in(h, v, xx, yy);
`else
        return !f_in(h, v, xx, yy);
`endif
    endfunction

    function automatic logic [7:0] f_byte(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0; m_idx = 0; m_we = 1'b0; m_addr = 0; m_din = 0;
        for (int i = 0; i < LAT; i++) m_hist[i] = 1'b0;
        last_acc = 1'b0;
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // model, then check registered outputs just after the edge.
    task automatic cycle();
        int  h, v, xx, yy;
        bit  ins, rdy, acc, dn;
        @(negedge clk);
        h = int'(hcount); v = int'(vcount); xx = int'(x); yy = int'(y);
        ins = f_in(h, v, xx, yy);
        rdy = m_loading && f_window(h, v, xx, yy);
        acc = rdy && wr_valid && !load_abort;
        dn  = acc && (m_idx == NPIX - 1);
        chk("wr_ready", int'(wr_ready), int'(rdy));
        chk("busy", int'(busy), int'(m_loading));
        chk("done", int'(done), int'(dn));
        if (done) done_seen++;
        if (acc) begin
            m_we = 1'b1; m_addr = m_idx; m_din = int'(wr_data);
        end else begin
            m_we = 1'b0;
            if (ins) m_addr = f_rd(h, v, xx, yy);
        end
        if (m_loading) begin
            if (load_abort) begin
                m_loading = 1'b0; m_idx = 0;
            end else if (acc) begin
                m_idx++;
                if (m_idx == NPIX) begin m_loading = 1'b0; m_idx = 0; end
            end
        end else if (load_start && !load_abort) begin
            m_loading = 1'b1; m_idx = 0;
        end
        for (int i = LAT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = ins;
        last_acc = acc;
        @(posedge clk); #1;
        chk("ram_we", int'(ram_we), int'(m_we));
        chk("ram_addr", int'(ram_addr), m_addr);
        chk("ram_din", int'(ram_din), m_din);
        chk("in_sprite_out", int'(in_sprite_o), int'(m_hist[LAT-1]));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, int'(wr_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_we"}, int'(ram_we), 0);
        chk({tag, "_addr"}, int'(ram_addr), 0);
        chk({tag, "_din"}, int'(ram_din), 0);
        chk({tag, "_in_sprite"}, int'(in_sprite_o), 0);
    endtask

    // Feed bytes at a non-sprite blanking pixel until the model reaches byte n.
    task automatic feed_until(input int n);
        int guard = 0;
        hcount = 11'd1290; vcount = 10'd400; wr_valid = 1'b1;
        while (m_idx < n && guard < 2 * NPIX) begin
            wr_data = f_byte(m_idx);
            cycle();
            guard++;
        end
        chk("feed_reached", m_idx, n);
    endtask

    initial begin
        tbl[0]  = '{10,   10,  0,    0,    1, 2570};
        tbl[1]  = '{1279, 5,   1200, 0,    1, 79 + 5 * 256};
        tbl[2]  = '{300,  10,  0,    0,    0, 79 + 5 * 256};
        tbl[3]  = '{1455, 719, 1200, 464,  1, 65535};
        tbl[4]  = '{1456, 719, 1200, 464,  0, 65535};
        tbl[5]  = '{1200, 463, 1200, 464,  0, 65535};
        tbl[6]  = '{1200, 464, 1200, 464,  1, 0};
        tbl[7]  = '{255,  255, 0,    0,    1, 65535};
        tbl[8]  = '{256,  0,   0,    0,    0, 65535};
        tbl[9]  = '{0,    0,   2047, 1023, 0, 65535};
        tbl[10] = '{2047, 1023, 2047, 1023, 1, 0};

        rst_n = 1'b0; hcount = 11'd0; vcount = 10'd0; x = 11'd0; y = 10'd0;
        load_start = 1'b0; load_abort = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        model_reset();
        done_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Raster read table (loader idle)
        for (int i = 0; i < 11; i++) begin
            hcount = 11'(tbl[i].h); vcount = 10'(tbl[i].v);
            x = 11'(tbl[i].x); y = 10'(tbl[i].y);
            cycle();
            chk("tbl_addr", int'(ram_addr), tbl[i].exp_addr);
            chk("tbl_we", int'(ram_we), 0);
            repeat (LAT - 1) cycle();
            chk("tbl_in_sprite_lag", int'(in_sprite_o), tbl[i].exp_in);
        end

        // Arbitration
        x = 11'd0; y = 10'd0; hcount = 11'd1290; vcount = 10'd400;
        load_start = 1'b1; cycle(); load_start = 1'b0;
        hcount = 11'd10; vcount = 10'd10; wr_valid = 1'b1; wr_data = 8'hA5;
        cycle();
        chk("arb_ready_in_sprite", int'(wr_ready), 0);
        chk("arb_read_addr", int'(ram_addr), 2570);
        chk("arb_no_write", int'(ram_we), 0);
        hcount = 11'd300; vcount = 10'd400; #1;
`ifdef SPRITE_LOAD_BLANK_ONLY_EN
        chk("arb_ready_visible", int'(wr_ready), 0);
`else
        chk("arb_ready_visible", int'(wr_ready), 1);
`endif
        hcount = 11'd1290; #1;
        chk("arb_ready_blank", int'(wr_ready), 1);
        cycle();
        chk("first_write_we", int'(ram_we), 1);
        chk("first_write_addr", int'(ram_addr), 0);
        chk("first_write_din", int'(ram_din), 8'hA5);
        wr_valid = 1'b0; load_abort = 1'b1; cycle(); load_abort = 1'b0;
        load_start = 1'b1; load_abort = 1'b1; cycle();
        chk("start_abort_idle", int'(busy), 0);
        load_start = 1'b0; load_abort = 1'b0;

        // Reset in the middle of a load at byte 37
        load_start = 1'b1; cycle(); load_start = 1'b0;
        feed_until(37);
        rst_n = 1'b0; wr_valid = 1'b0; #1;
        check_all_zero("midload_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        load_start = 1'b1; cycle(); load_start = 1'b0;
        wr_valid = 1'b1; wr_data = f_byte(0); cycle();
        chk("restart_we", int'(ram_we), 1);
        chk("restart_addr", int'(ram_addr), 0);

        // Abort with a handshake at byte 100
        feed_until(100);
        load_abort = 1'b1; wr_valid = 1'b1; wr_data = f_byte(100);
        done_seen = 0;
        cycle();
        load_abort = 1'b0; wr_valid = 1'b0;
        chk("abort_no_write", int'(ram_we), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_no_done", done_seen, 0);
        load_start = 1'b1; cycle(); load_start = 1'b0;
        wr_valid = 1'b1; wr_data = f_byte(0); cycle();
        chk("abort_restart_addr", int'(ram_addr), 0);
        chk("abort_restart_we", int'(ram_we), 1);
        wr_valid = 1'b0; load_abort = 1'b1; cycle(); load_abort = 1'b0;

        // Full image load with valid held high
        x = 11'd0; y = 10'd0; hcount = 11'd1290; vcount = 10'd400;
        load_start = 1'b1; cycle(); load_start = 1'b0;
        done_seen = 0; wr_valid = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            wr_data = f_byte(i);
            cycle();
        end
        wr_valid = 1'b0;
        chk("full_done_count", done_seen, 1);
        chk("full_last_addr", int'(ram_addr), NPIX - 1);
        chk("full_idle", int'(busy), 0);
        cycle();

        // Randomized traffic
        x = 11'($urandom_range(0, 1300)); y = 10'($urandom_range(0, 700));
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                x = 11'($urandom_range(0, 2047)); y = 10'($urandom_range(0, 1023));
            end
            hcount = 11'($urandom_range(0, 1649));
            vcount = 10'($urandom_range(0, 749));
            load_start = ($urandom_range(0, 59) == 0);
            load_abort = ($urandom_range(0, 299) == 0);
            if (!wr_valid || last_acc) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_data  = 8'($urandom_range(0, 255));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
